seq_alu: RTL

Parametrised, registered successor to the processor's combinational ALU. It adds a persistent flag register with carry feedback for ADDC/SUBC, immediate operand selection with sign or zero extension, and a signed bidirectional shift-by-register. It also adds a multi-cycle shift-add multiplier behind a start/ready/result_valid handshake. It sits in the execute stage between the register-file read ports and write-back, and the flag register feeds the branch unit.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/seq_mul.sv | 77 +++++++
 rtl/seq_alu.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, flag bit positions,
// control FSM states and the immediate-extension rule.
package alu_pkg;

    // Operation codes; 4'hC..4'hF are undefined and flagged as invalid.
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADDC = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SUBC = 4'h3;
    localparam logic [3:0] OP_CMP  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_MOV  = 4'h8;
    localparam logic [3:0] OP_LSH  = 4'h9;
    localparam logic [3:0] OP_ASHU = 4'hA;
    localparam logic [3:0] OP_MUL  = 4'hB;

    // Bit positions inside the flag register {N,Z,F,L,C}.
    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } state_e;

    // Logic ops and MOV treat the immediate as an unsigned mask/constant;
    // everything else (arithmetic, compare, multiply, shift amount) is signed.
    function automatic logic imm_zero_ext(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR) || (op == OP_MOV);
    endfunction

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH
// iterations, low WIDTH bits of the product. The low half of a two's
// complement product does not depend on signedness, so an unsigned
// shift-add gives the correct truncated signed result.
module seq_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int CNT_W = $clog2(WIDTH);

    logic             busy_q,   busy_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] acc_step;

    // Next-state for one shift-add iteration; done is raised on the last one
    // so the parent can register the product on that same edge.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        done_o   = 1'b0;
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        if (start_i) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                busy_d = 1'b0;
                done_o = 1'b1;
            end
        end
    end

    assign product_o = acc_step;

    // Multiplier state registers; reset abandons any multiply in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered execute-stage ALU with persistent {N,Z,F,L,C} flags, immediate
// operand selection, signed bidirectional shifts and an iterative multiplier
// behind a start/ready/result_valid handshake.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IMM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             use_imm,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [IMM_W-1:0] imm,
    output logic             ready,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags,
    output logic             invalid
);

    localparam int               MSB     = WIDTH - 1;
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       flags_q, flags_d;
    logic             valid_q, valid_d;
    logic             invalid_q, invalid_d;

    logic [WIDTH-1:0] be, imm_sext, imm_zext;
    logic [WIDTH-1:0] alu_r, shamt;
    logic [4:0]       alu_flags;
    logic             alu_invalid, sh_neg, sh_big;
    logic [WIDTH:0]   sum_w, diff_w;
    logic             mul_start, mul_done;
    logic [WIDTH-1:0] mul_product;

    assign imm_sext = {{(WIDTH - IMM_W){imm[IMM_W-1]}}, imm};
    assign imm_zext = {{(WIDTH - IMM_W){1'b0}}, imm};
    assign be       = use_imm ? (imm_zero_ext(op) ? imm_zext : imm_sext) : b;

    // Signed shift amount: non-negative shifts left, negative shifts right by the magnitude.
    assign sh_neg = be[MSB];
    assign shamt  = sh_neg ? (~be + 1'b1) : be;
    assign sh_big = (shamt >= WIDTH_V);

    // Single-cycle op results and flag updates; carry comes from the registered flags.
    always_comb begin
        alu_r       = '0;
        alu_flags   = flags_q;
        alu_invalid = 1'b0;
        sum_w       = {1'b0, a} + {1'b0, be} + (WIDTH + 1)'((op == OP_ADDC) && flags_q[FLAG_C]);
        diff_w      = {1'b0, a} - {1'b0, be} - (WIDTH + 1)'((op == OP_SUBC) && flags_q[FLAG_C]);
        case (op)
            OP_ADD, OP_ADDC: begin
                alu_r             = sum_w[MSB:0];
                alu_flags[FLAG_C] = sum_w[WIDTH];
                alu_flags[FLAG_F] = (a[MSB] == be[MSB]) && (alu_r[MSB] != a[MSB]);
                alu_flags[FLAG_Z] = (alu_r == '0);
            end
            OP_SUB, OP_SUBC: begin
                alu_r             = diff_w[MSB:0];
                alu_flags[FLAG_C] = diff_w[WIDTH];
                alu_flags[FLAG_F] = (a[MSB] != be[MSB]) && (alu_r[MSB] != a[MSB]);
                alu_flags[FLAG_Z] = (alu_r == '0);
            end
            OP_CMP: begin
                alu_flags[FLAG_L] = (a < be);
                alu_flags[FLAG_N] = ($signed(a) < $signed(be));
                alu_flags[FLAG_Z] = (a == be);
            end
            OP_AND: alu_r = a & be;
            OP_OR:  alu_r = a | be;
            OP_XOR: alu_r = a ^ be;
            OP_MOV: alu_r = be;
            OP_LSH: begin
                if (sh_big)      alu_r = '0;
                else if (sh_neg) alu_r = a >> shamt;
                else             alu_r = a << shamt;
            end
            OP_ASHU: begin
                if (sh_neg) alu_r = sh_big ? {WIDTH{a[MSB]}} : WIDTH'($signed(a) >>> shamt);
                else        alu_r = sh_big ? '0 : a << shamt;
            end
            OP_MUL:  alu_r = '0;
            default: alu_invalid = 1'b1;
        endcase
    end

    // Handshake FSM: single-cycle ops complete in IDLE, MUL parks in MUL_RUN until done.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        flags_d   = flags_q;
        valid_d   = 1'b0;
        invalid_d = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = ST_MUL_RUN;
                    end else begin
                        result_d  = alu_r;
                        flags_d   = alu_flags;
                        valid_d   = 1'b1;
                        invalid_d = alu_invalid;
                    end
                end
            end
            ST_MUL_RUN: begin
                if (mul_done) begin
                    result_d         = mul_product;
                    flags_d[FLAG_Z]  = (mul_product == '0);
                    valid_d          = 1'b1;
                    state_d          = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Architectural state: FSM, result, flags and the completion pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            flags_q   <= '0;
            valid_q   <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            valid_q   <= valid_d;
            invalid_q <= invalid_d;
        end
    end

    seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start_i   (mul_start),
        .a_i       (a),
        .b_i       (be),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    assign ready        = (state_q == ST_IDLE);
    assign result_valid = valid_q;
    assign result       = result_q;
    assign flags        = flags_q;
    assign invalid      = invalid_q;

endmodule
